decompressor_unpacker: RTL and testbench
========================================

Name: decompressor_unpacker

Overview:
- Receive end of the compression stream: takes packed 256-bit beats of variable-length groups and restores eight 32-bit words per group.
- Each group is a 16-bit tag field followed by payloads, packed LSB-first and contiguous across beats.
- Sits between the decompression input AXI-stream FIFO and the downstream consumer, mirroring the compressor's packing/align stage.

Parameters:
- DATA_WIDTH, 32, uncompressed word width
- NUM_DATA, 8, words per group
- TAG_WIDTH, 2, tag bits per word
- BUF_BITS, 528, bit-buffer capacity (272 max group + 256 beat)
- CNT_WIDTH, 10, width of buffer fill counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- data_in  in  256  packed beat, bit 0 = oldest
- tvalid_in  in  1  input beat valid
- tlast_in  in  1  final beat of packet
- tkeep_in  in  32  valid bytes of the beat, contiguous from byte 0; all ones except on the tlast beat
- tready_out  out  1  beat accepted when tvalid_in && tready_out
- data_out  out  256  eight restored words, word0 in bits [31:0]
- tvalid_out  out  1  output valid
- tlast_out  out  1  last group of packet
- tready_in  in  1  downstream ready
- err_out  out  1  sticky truncated-packet flag

Behaviour:
- Tag field: tag i = bits [2i+1:2i].
  - 00: zero word, 0 payload bits.
  - 01: 8-bit payload, sign-extended.
  - 10: 16-bit payload, sign-extended.
  - 11: 32-bit raw payload.
  - Payloads follow word0..word7 in order.
- Group length: len = 16 + sum(payload bits); range 16..272; computed combinationally from the low 16 buffer bits.
- State: buf[BUF_BITS-1:0] and cnt (valid bits, LSB-aligned).
- FSM has two states:
  - FILL: tready_out = (cnt <= 272). An accepted beat is appended at bit cnt; cnt += 8*popcount(tkeep_in). If tlast_in is set, go to DRAIN.
  - DRAIN: tready_out = 0. Decode until remaining < 16, then resolve the residual (below) and return to FILL.
- Decode condition: cnt >= 16, cnt >= len, and output slot free (!tvalid_out || tready_in). On decode, buf >>= len and cnt -= len.
- Simultaneous decode and accept in one cycle: new buf = (buf >> len) | (beat << (cnt - len)); cnt = cnt - len + beat bits.
- Output register: data_out/tvalid_out/tlast_out load one cycle after decode (1-cycle latency) and hold while tvalid_out && !tready_in.
- tlast_out = 1 when the decode happens in DRAIN and cnt - len < 16.
- Residual handling in DRAIN when cnt < len or cnt < 16:
  - residual < 8 bits: discard, cnt := 0, return to FILL.
  - residual >= 8 bits (truncated group): discard, emit one all-zero beat with tlast_out=1, set err_out, return to FILL.
  - empty packet (residual < 8, no group emitted): no output beat.
- Throughput: one group per cycle while data suffices.
- Reset (async, active-low): buf=0, cnt=0, state=FILL, tvalid_out=0, tlast_out=0, data_out=0, err_out=0, tready_out=0.
  - tready_out rises the first cycle after reset release.
  - Reset mid-packet discards all buffered bits.
- err_out clears only on reset.

Decomposition:
- Shared package decomp_pkg holds:
  - tag encodings TAG_ZERO/TAG_B8/TAG_B16/TAG_RAW
  - payload-width function
  - MAX_GROUP_BITS=272
  - DATA_WIDTH/NUM_DATA/TAG_WIDTH constants, shared with the compressor side
- One sub-module, group_expander, is natural: combinational; input 272-bit window; outputs len and 256-bit restored words via a prefix-sum of payload widths.
- Top level holds the FSM, bit buffer and output register.

Test Plan:
- Single group, tags 0x0000, beat data 0x0000, tkeep=0x00000003, tlast -> one output beat, data_out=0, tlast_out=1, err_out=0.
- All-raw group (tags 0xFFFF, words 0x11111111..0x88888888):
  - Stimulus: beat1 full; beat2 tkeep=0x00000003 with tlast.
  - Response: one beat with word k = 0x(k+1) repeated, tlast_out=1.
- Mixed group: tags 01,10,11,00×5 (0x0039) with payloads 0x80, 0x7FFF, 0xDEADBEEF -> words 0xFFFFFF80, 0x00007FFF, 0xDEADBEEF, then 0×5; len=72 bits.
- Ten all-zero groups (160 bits) in one beat, tkeep=0x000FFFFF, tready_in toggling 1/0 -> exactly 10 beats in order, no loss or duplication, tlast_out only on the 10th.
- Truncated packet: tags 0xFFFF with only 48 payload bits and tlast -> zero beat with tlast_out=1, err_out=1 and sticky; the next packet decodes correctly.
- Assert reset mid-DRAIN with tvalid_out high -> tvalid_out=0 immediately; after release the next packet decodes from a clean buffer.

Source files
------------

// File: rtl/decomp_pkg.sv
// rtl/decomp_pkg.sv - shared tag encodings and group geometry for the compression stream
package decomp_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int NUM_DATA       = 8;
  localparam int TAG_WIDTH      = 2;
  localparam int TAG_BITS       = NUM_DATA * TAG_WIDTH;
  localparam int BEAT_BITS      = NUM_DATA * DATA_WIDTH;
  localparam int MAX_GROUP_BITS = TAG_BITS + BEAT_BITS;

  typedef enum logic [TAG_WIDTH-1:0] {
    TAG_ZERO = 2'b00,
    TAG_B8   = 2'b01,
    TAG_B16  = 2'b10,
    TAG_RAW  = 2'b11
  } tag_e;

  function automatic logic [5:0] payload_width(input logic [TAG_WIDTH-1:0] tag);
    case (tag)
      TAG_B8:  return 6'd8;
      TAG_B16: return 6'd16;
      TAG_RAW: return 6'd32;
      default: return 6'd0;
    endcase
  endfunction
endpackage

// File: rtl/group_expander.sv
// rtl/group_expander.sv - combinational decode of one group window into length and eight words
module group_expander
  import decomp_pkg::*;
#(
  parameter int CNT_WIDTH = 10
) (
  input  logic [MAX_GROUP_BITS-1:0] window,
  output logic [CNT_WIDTH-1:0]      len,
  output logic [BEAT_BITS-1:0]      words
);
  logic [CNT_WIDTH-1:0]      off;
  logic [MAX_GROUP_BITS-1:0] piece;
  logic [TAG_WIDTH-1:0]      tag;

  // off is the running prefix sum of payload widths, starting after the tag field
  always_comb begin
    off   = CNT_WIDTH'(TAG_BITS);
    words = '0;
    piece = '0;
    tag   = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      tag   = window[i*TAG_WIDTH +: TAG_WIDTH];
      piece = window >> off;
      case (tag)
        TAG_B8:  words[i*DATA_WIDTH +: DATA_WIDTH] = {{24{piece[7]}}, piece[7:0]};
        TAG_B16: words[i*DATA_WIDTH +: DATA_WIDTH] = {{16{piece[15]}}, piece[15:0]};
        TAG_RAW: words[i*DATA_WIDTH +: DATA_WIDTH] = piece[31:0];
        default: words[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      endcase
      off = off + CNT_WIDTH'(payload_width(tag));
    end
    len = off;
  end
endmodule

// File: rtl/decompressor_unpacker.sv
// rtl/decompressor_unpacker.sv - bit buffer, fill/drain FSM and output register for group unpacking
module decompressor_unpacker
  import decomp_pkg::*;
#(
  parameter int BUF_BITS  = 528,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BEAT_BITS-1:0] data_in,
  input  logic                 tvalid_in,
  input  logic                 tlast_in,
  input  logic [31:0]          tkeep_in,
  output logic                 tready_out,
  output logic [BEAT_BITS-1:0] data_out,
  output logic                 tvalid_out,
  output logic                 tlast_out,
  input  logic                 tready_in,
  output logic                 err_out
);
  typedef enum logic {FILL, DRAIN} state_e;

  state_e               state, nxt_state;
  logic [BUF_BITS-1:0]  bit_buf, nxt_buf, buf_after;
  logic [CNT_WIDTH-1:0] cnt, nxt_cnt, cnt_after, beat_bits, grp_len;
  logic [BEAT_BITS-1:0] grp_words, beat_masked;
  logic                 accept, slot_free, have_group, decode, emit_trunc;

  group_expander #(.CNT_WIDTH(CNT_WIDTH)) u_expander (
    .window (bit_buf[MAX_GROUP_BITS-1:0]),
    .len    (grp_len),
    .words  (grp_words)
  );

  assign accept     = tvalid_in && tready_out && (state == FILL);
  assign slot_free  = !tvalid_out || tready_in;
  assign have_group = (cnt >= CNT_WIDTH'(TAG_BITS)) && (cnt >= grp_len);
  assign decode     = have_group && slot_free;
  assign cnt_after  = decode ? cnt - grp_len : cnt;
  assign buf_after  = decode ? bit_buf >> grp_len : bit_buf;

  // Bits above cnt are kept zero so a new beat can simply be OR-ed in
  always_comb begin
    beat_bits   = '0;
    beat_masked = '0;
    for (int b = 0; b < 32; b++) begin
      beat_masked[b*8 +: 8] = tkeep_in[b] ? data_in[b*8 +: 8] : 8'h00;
      beat_bits = beat_bits + (tkeep_in[b] ? CNT_WIDTH'(8) : CNT_WIDTH'(0));
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_buf    = buf_after;
    nxt_cnt    = cnt_after;
    emit_trunc = 1'b0;
    if (accept) begin
      nxt_buf = buf_after | (BUF_BITS'(beat_masked) << cnt_after);
      nxt_cnt = cnt_after + beat_bits;
      if (tlast_in) nxt_state = DRAIN;
    end
    if (state == DRAIN && !have_group) begin
      // A residual of a byte or more means the packet ended mid-group
      if (cnt < CNT_WIDTH'(8)) begin
        nxt_buf   = '0;
        nxt_cnt   = '0;
        nxt_state = FILL;
      end else if (slot_free) begin
        nxt_buf    = '0;
        nxt_cnt    = '0;
        nxt_state  = FILL;
        emit_trunc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      bit_buf    <= '0;
      cnt        <= '0;
      tready_out <= 1'b0;
      data_out   <= '0;
      tvalid_out <= 1'b0;
      tlast_out  <= 1'b0;
      err_out    <= 1'b0;
    end else begin
      state      <= nxt_state;
      bit_buf    <= nxt_buf;
      cnt        <= nxt_cnt;
      tready_out <= (nxt_state == FILL) && (nxt_cnt <= CNT_WIDTH'(MAX_GROUP_BITS));
      if (decode) begin
        data_out   <= grp_words;
        tvalid_out <= 1'b1;
        tlast_out  <= (state == DRAIN) && (cnt_after < CNT_WIDTH'(TAG_BITS));
      end else if (emit_trunc) begin
        data_out   <= '0;
        tvalid_out <= 1'b1;
        tlast_out  <= 1'b1;
        err_out    <= 1'b1;
      end else if (tready_in) begin
        tvalid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_decompressor_unpacker.sv
// tb/tb_decompressor_unpacker.sv - self-checking bench for decompressor_unpacker
module tb_decompressor_unpacker;
  import decomp_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] data_in = '0;
  logic         tvalid_in = 1'b0;
  logic         tlast_in = 1'b0;
  logic [31:0]  tkeep_in = '0;
  logic         tready_out;
  logic [255:0] data_out;
  logic         tvalid_out;
  logic         tlast_out;
  logic         tready_in = 1'b0;
  logic         err_out;

  always #5 clk = ~clk;

  decompressor_unpacker dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .tvalid_in  (tvalid_in),
    .tlast_in   (tlast_in),
    .tkeep_in   (tkeep_in),
    .tready_out (tready_out),
    .data_out   (data_out),
    .tvalid_out (tvalid_out),
    .tlast_out  (tlast_out),
    .tready_in  (tready_in),
    .err_out    (err_out)
  );

  typedef struct packed {
    logic [255:0] data;
    logic         last;
    logic         err;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           rdy_mode = 0;
  logic         exp_err = 1'b0;
  logic [8191:0] pkt;
  int           nbits;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int group_len(input logic [15:0] tags);
    int n = 16;
    for (int i = 0; i < 8; i++)
      n += (tags[2*i +: 2] == 2'b01) ? 8 : (tags[2*i +: 2] == 2'b10) ? 16 : (tags[2*i +: 2] == 2'b11) ? 32 : 0;
    return n;
  endfunction

  function automatic logic [31:0] restore(input logic [1:0] tag, input logic [31:0] v);
    case (tag)
      2'b01:   return 32'(signed'(v[7:0]));
      2'b10:   return 32'(signed'(v[15:0]));
      2'b11:   return v;
      default: return 32'h0;
    endcase
  endfunction

  task automatic start_pkt();
    pkt = '0;
    nbits = 0;
  endtask

  task automatic append(input logic [31:0] v, input int w);
    for (int b = 0; b < w; b++) pkt[nbits + b] = v[b];
    nbits += w;
  endtask

  task automatic add_group(input logic [15:0] tags, input logic [255:0] vals);
    append({16'h0, tags}, 16);
    for (int i = 0; i < 8; i++)
      append(vals[i*32 +: 32], (tags[2*i +: 2] == 2'b01) ? 8 : (tags[2*i +: 2] == 2'b10) ? 16 :
                               (tags[2*i +: 2] == 2'b11) ? 32 : 0);
  endtask

  task automatic push_exp(input logic [255:0] d, input logic last);
    exp_q.push_back('{data: d, last: last, err: exp_err});
  endtask

  task automatic send_packet(input int gap_max);
    int nbeats = (nbits + 255) / 256;
    for (int j = 0; j < nbeats; j++) begin
      int rem = nbits - j * 256;
      int bytes = (rem >= 256) ? 32 : (rem + 7) / 8;
      int t = 0;
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      #1;
      data_in   = pkt[j*256 +: 256];
      for (int b = bytes; b < 32; b++) data_in[b*8 +: 8] = 8'($urandom);
      tkeep_in  = (bytes == 32) ? 32'hFFFF_FFFF : (32'h1 << bytes) - 32'h1;
      tlast_in  = (j == nbeats - 1);
      tvalid_in = 1'b1;
      do begin
        @(negedge clk);
        t++;
      end while (!tready_out && t < 500);
      if (!tready_out) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: tready_out=%0b required 1", tready_out);
      end
      @(posedge clk);
      #1;
      tvalid_in = 1'b0;
      tlast_in  = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       tready_in = 1'b1;
      1:       tready_in = ~tready_in;
      2:       tready_in = ($urandom_range(0, 3) != 0);
      default: tready_in = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (reset && tvalid_out && tready_in) begin
      beat_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %h expected none", data_out);
      end else begin
        e = exp_q.pop_front();
        check("data_out", data_out, e.data);
        check("tlast_out", 256'(tlast_out), 256'(e.last));
        check("err_out", 256'(err_out), 256'(e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] vals, expw;
    logic [15:0]  tags;
    int           ngrp;

    check("model_len_mixed", 256'(group_len(16'h0039)), 256'd72);
    check("model_len_raw", 256'(group_len(16'hFFFF)), 256'd272);
    check("model_len_zero", 256'(group_len(16'h0000)), 256'd16);

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 256'(tvalid_out), 256'd0);
    check("rst_tlast", 256'(tlast_out), 256'd0);
    check("rst_data", data_out, 256'd0);
    check("rst_err", 256'(err_out), 256'd0);
    check("rst_tready", 256'(tready_out), 256'd0);
    reset = 1'b1;
    @(negedge clk);
    check("tready_before_edge", 256'(tready_out), 256'd0);
    @(posedge clk);
    #1;
    check("tready_after_release", 256'(tready_out), 256'd1);

    // single all-zero group
    rdy_mode = 0;
    start_pkt();
    append(32'h0, 16);
    push_exp('0, 1'b1);
    send_packet(0);
    wait_drain("single_zero");

    // all-raw group spanning two beats
    start_pkt();
    vals = '0;
    for (int k = 0; k < 8; k++) vals[k*32 +: 32] = 32'h1111_1111 * (k + 1);
    add_group(16'hFFFF, vals);
    push_exp({32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
              32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1'b1);
    send_packet(2);
    wait_drain("all_raw");

    // mixed tags with sign extension
    start_pkt();
    append(32'h0039, 16);
    append(32'h80, 8);
    append(32'h7FFF, 16);
    append(32'hDEADBEEF, 32);
    push_exp({160'h0, 32'hDEADBEEF, 32'h00007FFF, 32'hFFFFFF80}, 1'b1);
    send_packet(0);
    wait_drain("mixed");

    // ten zero groups with toggling downstream ready
    rdy_mode = 1;
    start_pkt();
    for (int g = 0; g < 10; g++) begin
      append(32'h0, 16);
      push_exp('0, g == 9);
    end
    send_packet(0);
    wait_drain("ten_zero");

    // truncated packet, then a clean packet with err still sticky
    rdy_mode = 0;
    start_pkt();
    append(32'hFFFF, 16);
    append(32'h1234_5678, 32);
    append(32'h9ABC, 16);
    exp_err = 1'b1;
    push_exp('0, 1'b1);
    send_packet(0);
    wait_drain("truncated");
    check("err_sticky", 256'(err_out), 256'd1);
    start_pkt();
    append(32'h0039, 16);
    append(32'h80, 8);
    append(32'h7FFF, 16);
    append(32'hDEADBEEF, 32);
    push_exp({160'h0, 32'hDEADBEEF, 32'h00007FFF, 32'hFFFFFF80}, 1'b1);
    send_packet(0);
    wait_drain("after_trunc");

    // reset while DRAIN holds an output beat
    rdy_mode = 3;
    start_pkt();
    for (int g = 0; g < 10; g++) append(32'h0, 16);
    send_packet(0);
    repeat (4) @(negedge clk);
    check("pre_reset_tvalid", 256'(tvalid_out), 256'd1);
    reset = 1'b0;
    #1;
    check("async_rst_tvalid", 256'(tvalid_out), 256'd0);
    check("async_rst_err", 256'(err_out), 256'd0);
    check("async_rst_tready", 256'(tready_out), 256'd0);
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    check("tready_after_midreset", 256'(tready_out), 256'd1);
    start_pkt();
    append(32'h0039, 16);
    append(32'h80, 8);
    append(32'h7FFF, 16);
    append(32'hDEADBEEF, 32);
    push_exp({160'h0, 32'hDEADBEEF, 32'h00007FFF, 32'hFFFFFF80}, 1'b1);
    send_packet(0);
    wait_drain("post_reset");

    // randomized packets of whole groups against the model
    rdy_mode = 2;
    for (int p = 0; p < 30; p++) begin
      start_pkt();
      ngrp = $urandom_range(1, 5);
      for (int g = 0; g < ngrp; g++) begin
        tags = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
          vals[i*32 +: 32] = $urandom;
          expw[i*32 +: 32] = restore(tags[2*i +: 2], vals[i*32 +: 32]);
        end
        add_group(tags, vals);
        push_exp(expw, g == ngrp - 1);
      end
      send_packet(3);
      wait_drain("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
